// File: rtl/nios2os_jtag_mon_access_ctrl.sv
// nios2os_jtag_mon_access_ctrl: sysclk-side debug monitor single-word Avalon-MM access engine
module nios2os_jtag_mon_access_ctrl #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    input  logic              m_waitrequest
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       cnt;
    logic              ld_pend;
    logic              go_ld, go_rd, go_wr, in_xfer, xfer_ok, tmo;
    logic              unused_bits;

    assign unused_bits = ^{jdo[37:35], jdo[1:0]};

    // Strobe decode (IDLE only, fixed priority a > b > no_action) and transfer completion/abort
    always_comb begin
        go_ld     = (state == IDLE) && take_action_ocimem_a;
        go_wr     = (state == IDLE) && !take_action_ocimem_a && take_action_ocimem_b;
        go_rd     = (state == IDLE) && (take_action_ocimem_a ? jdo[34] :
                    (!take_action_ocimem_b && take_no_action_ocimem_a));
        in_xfer   = (state == RD) || (state == WR);
        xfer_ok   = in_xfer && !m_waitrequest;
        tmo       = in_xfer && m_waitrequest && (cnt == 16'(TIMEOUT_CYCLES - 1));
        state_nxt = (state == IDLE) ? (go_rd ? RD : go_wr ? WR : IDLE) :
                    (state == DONE) ? IDLE :
                    xfer_ok ? DONE : tmo ? IDLE : state;
    end

    // State register plus registered master requests, status flags and data capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            addr          <= '0;
            cnt           <= '0;
            ld_pend       <= 1'b0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            busy          <= 1'b0;
            m_address     <= '0;
            m_read        <= 1'b0;
            m_write       <= 1'b0;
            m_writedata   <= '0;
        end else begin
            state   <= state_nxt;
            m_read  <= state_nxt == RD;
            m_write <= state_nxt == WR;
            busy    <= state_nxt != IDLE;
            ld_pend <= go_ld && !jdo[34];
            if (ld_pend || state == DONE || tmo)
                monitor_ready <= 1'b1;
            if (tmo)
                monitor_error <= 1'b1;
            if (go_ld || go_rd || go_wr) begin
                monitor_ready <= 1'b0;
                monitor_error <= 1'b0;
            end
            if (go_ld)
                addr <= jdo[ADDR_W+1:2];
            if (state == DONE)
                addr <= addr + 1'b1;
            if (go_rd || go_wr) begin
                cnt       <= '0;
                m_address <= go_ld ? jdo[ADDR_W+1:2] : addr;
            end else if (in_xfer && m_waitrequest) begin
                cnt <= cnt + 1'b1;
            end
            if (go_wr) begin
                m_writedata <= jdo[34:3];
                MonDReg     <= jdo[34:3];
            end
            if (state == RD && xfer_ok)
                MonDReg <= m_readdata;
        end
    end
endmodule

// File: tb/tb_nios2os_jtag_mon_access_ctrl.sv
// tb_nios2os_jtag_mon_access_ctrl: directed self-checking bench for the monitor access controller
module tb_nios2os_jtag_mon_access_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        ta_a, ta_b, tn_a;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, busy;
    logic [7:0]  m_address;
    logic        m_read, m_write;
    logic [31:0] m_writedata, m_readdata;
    logic        m_waitrequest;
    int          errors = 0;
    int          checks = 0;

    nios2os_jtag_mon_access_ctrl #(.ADDR_W(8), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
        .take_no_action_ocimem_a(tn_a),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .busy(busy), .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] mk_addr(input logic rd, input logic [7:0] a);
        logic [37:0] j;
        j = '0;
        j[34] = rd;
        j[9:2] = a;
        return j;
    endfunction

    function automatic logic [37:0] mk_data(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic run_cmd(input logic a, input logic b, input logic n, input logic [37:0] j);
        jdo = j; ta_a = a; ta_b = b; tn_a = n;
        @(negedge clk);
        ta_a = 1'b0; ta_b = 1'b0; tn_a = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({MonDReg, monitor_ready, monitor_error, busy} !== 35'h0) begin
            errors++; $display("FAIL reset_status: got %h expected 0", {MonDReg, monitor_ready, monitor_error, busy});
        end
        checks++;
        if ({m_address, m_read, m_write, m_writedata} !== 42'h0) begin
            errors++; $display("FAIL reset_master: got %h expected 0", {m_address, m_read, m_write, m_writedata});
        end
    endtask

    task automatic test_addr_load();
        run_cmd(1, 0, 0, mk_addr(0, 8'h10));
        checks++;
        if ({m_read, m_write, busy, monitor_ready} !== 4'b0000) begin
            errors++; $display("FAIL load_no_activity: got %b expected 0000", {m_read, m_write, busy, monitor_ready});
        end
        @(negedge clk);
        checks++;
        if (monitor_ready !== 1'b1) begin
            errors++; $display("FAIL load_ready: got %b expected 1", monitor_ready);
        end
    endtask

    task automatic test_read_zero_wait();
        m_waitrequest = 1'b0;
        m_readdata = 32'hDEADBEEF;
        run_cmd(0, 0, 1, '0);
        checks++;
        if ({m_read, m_write, busy, monitor_ready, m_address} !== {4'b1010, 8'h10}) begin
            errors++; $display("FAIL rd_req: got %h expected %h", {m_read, m_write, busy, monitor_ready, m_address}, {4'b1010, 8'h10});
        end
        @(negedge clk);
        checks++;
        if ({m_read, monitor_ready, MonDReg} !== {2'b00, 32'hDEADBEEF}) begin
            errors++; $display("FAIL rd_done: got %h expected %h", {m_read, monitor_ready, MonDReg}, {2'b00, 32'hDEADBEEF});
        end
        @(negedge clk);
        checks++;
        if ({monitor_ready, monitor_error, busy} !== 3'b100) begin
            errors++; $display("FAIL rd_ready: got %b expected 100", {monitor_ready, monitor_error, busy});
        end
        m_readdata = 32'hCAFEF00D;
        run_cmd(0, 0, 1, '0);
        checks++;
        if ({m_read, m_address} !== {1'b1, 8'h11}) begin
            errors++; $display("FAIL rd_next_addr: got %h expected %h", {m_read, m_address}, {1'b1, 8'h11});
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({monitor_ready, MonDReg} !== {1'b1, 32'hCAFEF00D}) begin
            errors++; $display("FAIL rd2_data: got %h expected %h", {monitor_ready, MonDReg}, {1'b1, 32'hCAFEF00D});
        end
    endtask

    task automatic test_write_wait();
        m_waitrequest = 1'b1;
        run_cmd(0, 1, 0, mk_data(32'h12345678));
        for (int i = 0; i < 4; i++) begin
            if (i == 3) m_waitrequest = 1'b0;
            checks++;
            if ({m_write, m_read, m_address, m_writedata} !== {2'b10, 8'h12, 32'h12345678}) begin
                errors++; $display("FAIL wr_hold%0d: got %h expected %h", i, {m_write, m_read, m_address, m_writedata}, {2'b10, 8'h12, 32'h12345678});
            end
            @(negedge clk);
        end
        checks++;
        if ({m_write, MonDReg} !== {1'b0, 32'h12345678}) begin
            errors++; $display("FAIL wr_done: got %h expected %h", {m_write, MonDReg}, {1'b0, 32'h12345678});
        end
        @(negedge clk);
        checks++;
        if ({monitor_ready, monitor_error, busy} !== 3'b100) begin
            errors++; $display("FAIL wr_ready: got %b expected 100", {monitor_ready, monitor_error, busy});
        end
    endtask

    task automatic test_timeout();
        m_waitrequest = 1'b1;
        m_readdata = 32'h55555555;
        run_cmd(0, 0, 1, '0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({m_read, m_address} !== {1'b1, 8'h13}) begin
                errors++; $display("FAIL to_hold%0d: got %h expected %h", i, {m_read, m_address}, {1'b1, 8'h13});
            end
            @(negedge clk);
        end
        checks++;
        if ({m_read, busy, monitor_ready, monitor_error, MonDReg} !== {4'b0011, 32'h12345678}) begin
            errors++; $display("FAIL to_abort: got %h expected %h", {m_read, busy, monitor_ready, monitor_error, MonDReg}, {4'b0011, 32'h12345678});
        end
        m_waitrequest = 1'b0;
        m_readdata = 32'h0BADF00D;
        run_cmd(0, 0, 1, '0);
        checks++;
        if ({m_read, m_address, monitor_error} !== {1'b1, 8'h13, 1'b0}) begin
            errors++; $display("FAIL to_addr_kept: got %h expected %h", {m_read, m_address, monitor_error}, {1'b1, 8'h13, 1'b0});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap_priority();
        logic [37:0] j;
        j = mk_data(32'hFFFFFFFF);
        j[9:2] = 8'hFF;
        j[34] = 1'b0;
        run_cmd(1, 1, 1, j);
        checks++;
        if ({m_write, m_read, busy, m_writedata, MonDReg} !== {3'b000, 32'h12345678, 32'h0BADF00D}) begin
            errors++; $display("FAIL prio_load_only: got %h expected %h", {m_write, m_read, busy, m_writedata, MonDReg}, {3'b000, 32'h12345678, 32'h0BADF00D});
        end
        @(negedge clk);
        m_readdata = 32'hA5A5A5A5;
        run_cmd(0, 0, 1, '0);
        checks++;
        if ({m_read, m_address} !== {1'b1, 8'hFF}) begin
            errors++; $display("FAIL wrap_ff: got %h expected %h", {m_read, m_address}, {1'b1, 8'hFF});
        end
        repeat (2) @(negedge clk);
        m_waitrequest = 1'b1;
        run_cmd(0, 0, 1, '0);
        checks++;
        if ({m_read, m_address} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL wrap_00: got %h expected %h", {m_read, m_address}, {1'b1, 8'h00});
        end
        run_cmd(0, 1, 0, mk_data(32'h77777777));
        checks++;
        if ({m_read, m_write, busy, m_writedata} !== {3'b101, 32'h12345678}) begin
            errors++; $display("FAIL busy_ignore: got %h expected %h", {m_read, m_write, busy, m_writedata}, {3'b101, 32'h12345678});
        end
        m_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({monitor_ready, monitor_error, busy, m_write, MonDReg} !== {4'b1000, 32'hA5A5A5A5}) begin
            errors++; $display("FAIL busy_ignore_end: got %h expected %h", {monitor_ready, monitor_error, busy, m_write, MonDReg}, {4'b1000, 32'hA5A5A5A5});
        end
    endtask

    task automatic test_async_reset();
        m_waitrequest = 1'b1;
        run_cmd(0, 1, 0, mk_data(32'h0F0F0F0F));
        checks++;
        if (m_write !== 1'b1) begin
            errors++; $display("FAIL ar_pre: got %b expected 1", m_write);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({m_write, m_read, busy, monitor_ready, monitor_error, m_address, MonDReg, m_writedata} !== 77'h0) begin
            errors++; $display("FAIL ar_clear: got %h expected 0", {m_write, m_read, busy, monitor_ready, monitor_error, m_address, MonDReg, m_writedata});
        end
        @(negedge clk);
        reset = 1'b0;
        m_waitrequest = 1'b0;
        m_readdata = 32'h11223344;
        run_cmd(1, 0, 0, mk_addr(1, 8'h20));
        checks++;
        if ({m_read, m_address} !== {1'b1, 8'h20}) begin
            errors++; $display("FAIL ar_next_req: got %h expected %h", {m_read, m_address}, {1'b1, 8'h20});
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({monitor_ready, MonDReg} !== {1'b1, 32'h11223344}) begin
            errors++; $display("FAIL ar_next_done: got %h expected %h", {monitor_ready, MonDReg}, {1'b1, 32'h11223344});
        end
    endtask

    initial begin
        reset = 1'b1;
        jdo = '0; ta_a = 1'b0; ta_b = 1'b0; tn_a = 1'b0;
        m_readdata = '0; m_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_addr_load();
        test_read_zero_wait();
        test_write_wait();
        test_timeout();
        test_wrap_priority();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
